// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters, with CS setup/hold/gap timing.
// Optional idle-grant watchdog is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4,
    parameter int TIMEOUT  = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   start,
    input  logic [NUM_REQ*8-1:0] wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   busy,
    output logic [7:0]           rdata,
    output logic                 spi_start,
    output logic [7:0]           spi_out,
    input  logic [7:0]           spi_in,
    input  logic                 spi_busy,
    output logic [NUM_REQ-1:0]   dev_cs_n
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CNT = max2(max2(CS_SETUP, CS_HOLD), max2(CS_GAP, TIMEOUT));
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_ACTIVE, ST_HOLD, ST_GAP
`ifdef SPI_ARB_TIMEOUT_EN
        , ST_TIMEOUT
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   win_q;      // current winner, doubles as last-granted for the scan
    logic [IDX_W-1:0]   pick;
    logic [NUM_REQ-1:0] pick_oh, req_elig, blocked;
    logic               found, grant_ld, cs_release, accept;
    logic               pend_q, sbusy_q;
    logic               win_req, win_start, win_busy;
    logic [7:0]         win_wdata;
`ifdef SPI_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   tmo_q;
    logic [NUM_REQ-1:0] revoked_q;
`endif

    always_comb begin
        win_req   = 1'b0;
        win_start = 1'b0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_q == IDX_W'(i)) begin
                win_req   = req[i];
                win_start = start[i];
                win_wdata = wdata[i*8 +: 8];
            end
        end
    end

    // Pending flag covers the gap between our spi_start and the master raising spi_busy.
    assign win_busy = spi_busy | pend_q;
    assign req_elig = req & ~blocked;

    always_comb begin
        int j;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(win_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_elig[j]) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end
    end

    always_comb begin
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_busy
        assign busy[i] = (state_q == ST_ACTIVE && win_q == IDX_W'(i)) ? win_busy
                       : (req[i] || state_q != ST_IDLE || blocked[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_ld   = 1'b0;
        cs_release = 1'b0;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d  = ST_SETUP;
                    cnt_d    = CNT_W'(CS_SETUP);
                    grant_ld = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_q <= CNT_W'(1)) state_d = ST_ACTIVE;
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
            ST_ACTIVE: begin
                // Nothing happens while a byte is in flight, so a byte is never truncated.
                if (!win_busy) begin
                    if (!win_req) begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(CS_HOLD);
                    end else if (win_start) begin
                        accept = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    end else if (tmo_q >= CNT_W'(TIMEOUT - 1)) begin
                        state_d = ST_TIMEOUT;
`endif
                    end
                end
            end
`ifdef SPI_ARB_TIMEOUT_EN
            ST_TIMEOUT: begin
                state_d = ST_HOLD;
                cnt_d   = CNT_W'(CS_HOLD);
            end
`endif
            ST_HOLD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d    = ST_GAP;
                    cnt_d      = CNT_W'(CS_GAP);
                    cs_release = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            win_q     <= IDX_W'(NUM_REQ - 1);
            gnt       <= '0;
            dev_cs_n  <= '1;
            spi_start <= 1'b0;
            spi_out   <= '0;
            rdata     <= '0;
            pend_q    <= 1'b0;
            sbusy_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sbusy_q   <= spi_busy;
            spi_start <= accept;
            if (grant_ld) begin
                win_q    <= pick;
                gnt      <= pick_oh;
                dev_cs_n <= ~pick_oh;
            end else if (cs_release) begin
                gnt      <= '0;
                dev_cs_n <= '1;
            end
            if (accept) begin
                spi_out <= win_wdata;
                pend_q  <= 1'b1;
            end else if (spi_busy) begin
                pend_q  <= 1'b0;
            end
            if (sbusy_q && !spi_busy) rdata <= spi_in;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // A revoked requester is kept off the scan until it drops req.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q     <= '0;
            revoked_q <= '0;
        end else begin
            if (state_q != ST_ACTIVE || accept) tmo_q <= '0;
            else if (!win_busy && tmo_q != '1)   tmo_q <= tmo_q + CNT_W'(1);
            revoked_q <= revoked_q & req;
            if (state_q == ST_TIMEOUT) revoked_q[win_q] <= 1'b1;
        end
    end
    assign blocked = revoked_q;
`else
    assign blocked = '0;
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: behavioural SPI master answers each byte with its complement after 3 cycles.
module tb_spi_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, start, gnt, busy, dev_cs_n;
    logic [15:0] wdata;
    logic [7:0]  rdata, spi_out, spi_in;
    logic        spi_start, spi_busy;

    int n_cmp = 0, n_err = 0, cyc = 0, last_fall = 0, n_pulses = 0;
    logic [7:0] exp_q[$];

    spi_bus_arbiter #(.NUM_REQ(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .wdata(wdata),
        .gnt(gnt), .busy(busy), .rdata(rdata), .spi_start(spi_start), .spi_out(spi_out),
        .spi_in(spi_in), .spi_busy(spi_busy), .dev_cs_n(dev_cs_n)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SPI master model; pops the scoreboard on every spi_start.
    initial begin
        logic [7:0] tx, e;
        spi_busy = 1'b0;
        spi_in   = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (spi_start === 1'b1) begin
                tx = spi_out;
                n_pulses++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL spi_start_unexpected: spi_out=%h, no byte expected", tx);
                end else begin
                    e = exp_q.pop_front();
                    if (tx !== e) begin
                        n_err++;
                        $display("FAIL spi_out_byte: got %h, need %h", tx, e);
                    end
                end
                spi_busy = 1'b1;
                repeat (3) begin @(posedge clk); #1; end
                spi_in    = ~tx;
                spi_busy  = 1'b0;
                last_fall = cyc + 1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: bench still running, need finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #3;
    endtask

    task automatic send_byte(input int i, input logic [7:0] b);
        int t = 0;
        while (busy[i] !== 1'b0 && t < 100) begin tick(); t++; end
        if (t >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL send_wait: busy[%0d]=%b, need 0", i, busy[i]);
        end
        wdata[i*8 +: 8] = b;
        start[i] = 1'b1;
        exp_q.push_back(b);
        tick();
        start[i] = 1'b0;
    endtask

    task automatic wait_gnt(output int at);
        int t = 0;
        while (gnt === 2'b00 && t < 100) begin tick(); t++; end
        at = cyc;
        if (t >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL grant_timeout: gnt=%b, need nonzero", gnt);
        end
    endtask

    task automatic wait_cs_high(output int at);
        int t = 0;
        while (dev_cs_n !== 2'b11 && t < 100) begin tick(); t++; end
        at = cyc;
        if (t >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL cs_release_timeout: dev_cs_n=%b, need 11", dev_cs_n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req = '0; start = '0; wdata = '0;
        tick(); tick();
        n_cmp++;
        if ({gnt, busy, rdata, spi_start, spi_out, dev_cs_n} !== {2'b00, 2'b00, 8'h00, 1'b0, 8'h00, 2'b11}) begin
            n_err++;
            $display("FAIL reset_values: gnt=%b busy=%b rdata=%h spi_start=%b spi_out=%h cs=%b, need 00 00 00 0 00 11",
                     gnt, busy, rdata, spi_start, spi_out, dev_cs_n);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int c0, ch, p0;
        logic [7:0] bytes [3];
        bytes[0] = 8'h2A; bytes[1] = 8'h00; bytes[2] = 8'h3F;
        p0 = n_pulses;
        req = 2'b01; c0 = cyc;
        tick();
        n_cmp++;
        if (gnt !== 2'b01 || dev_cs_n !== 2'b10) begin
            n_err++;
            $display("FAIL grant_latency: gnt=%b cs=%b, need 01 10", gnt, dev_cs_n);
        end
        for (int b = 0; b < 3; b++) begin
            send_byte(0, bytes[b]);
            n_cmp++;
            if (spi_start !== 1'b1 || dev_cs_n !== 2'b10) begin
                n_err++;
                $display("FAIL single_start: spi_start=%b cs=%b, need 1 10", spi_start, dev_cs_n);
            end
            if (b == 0) begin
                n_cmp++;
                if (cyc - c0 < 4) begin
                    n_err++;
                    $display("FAIL first_start_delay: got %0d cycles, need >= 4", cyc - c0);
                end
            end
        end
        tick();
        req = 2'b00;
        wait_cs_high(ch);
        n_cmp++;
        if (ch - last_fall != 2) begin
            n_err++;
            $display("FAIL cs_hold: CS high %0d cycles after fall, need 2", ch - last_fall);
        end
        n_cmp++;
        if (n_pulses - p0 != 3 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL single_pulses: got %0d pulses (%0d left), need 3 (0)", n_pulses - p0, exp_q.size());
        end
    endtask

    task automatic test_contention();
        int g, ch, exp_w;
        reset = 1'b0; req = '0;
        tick(); tick();
        reset = 1'b1;
        tick();
        req = 2'b11; exp_w = 0; ch = 0;
        for (int r = 0; r < 4; r++) begin
            wait_gnt(g);
            n_cmp++;
            if (gnt !== (2'b01 << exp_w)) begin
                n_err++;
                $display("FAIL rr_order: round %0d gnt=%b, need %b", r, gnt, 2'b01 << exp_w);
            end
            if (r > 0) begin
                n_cmp++;
                if (g - ch < 5) begin
                    n_err++;
                    $display("FAIL cs_gap: all-CS-high %0d cycles, need >= 5", g - ch);
                end
            end
            send_byte(exp_w, 8'h10 + 8'(r));
            req[exp_w] = 1'b0;
            wait_cs_high(ch);
            req[exp_w] = 1'b1;
            exp_w ^= 1;
        end
        req = 2'b00;
    endtask

    task automatic test_nongranted();
        int g, ch, t, p0;
        logic [7:0] so;
        req = 2'b01;
        wait_gnt(g);
        t = 0;
        while (busy[0] !== 1'b0 && t < 50) begin tick(); t++; end
        so = spi_out; p0 = n_pulses;
        wdata[15:8] = 8'h55; start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        n_cmp++;
        if (spi_start !== 1'b0 || spi_out !== so || busy[1] !== 1'b1) begin
            n_err++;
            $display("FAIL nongranted_start: spi_start=%b spi_out=%h busy1=%b, need 0 %h 1", spi_start, spi_out, busy[1], so);
        end
        tick(); tick();
        n_cmp++;
        if (n_pulses != p0) begin
            n_err++;
            $display("FAIL nongranted_queued: got %0d extra pulses, need 0", n_pulses - p0);
        end
        send_byte(0, 8'h77);
        req = 2'b00;
        wait_cs_high(ch);
    endtask

    task automatic test_early_release();
        int g, ch;
        req = 2'b01;
        wait_gnt(g);
        send_byte(0, 8'h5A);
        req = 2'b00;
        tick();
        n_cmp++;
        if (spi_busy !== 1'b1 || dev_cs_n !== 2'b10) begin
            n_err++;
            $display("FAIL early_release_cs: spi_busy=%b cs=%b, need 1 10", spi_busy, dev_cs_n);
        end
        wait_cs_high(ch);
        n_cmp++;
        if (ch - last_fall != 2) begin
            n_err++;
            $display("FAIL early_release_hold: CS high %0d cycles after fall, need 2", ch - last_fall);
        end
        n_cmp++;
        if (rdata !== 8'hA5) begin
            n_err++;
            $display("FAIL rdata_capture: got %h, need a5", rdata);
        end
    endtask

    task automatic test_reset_mid();
        int g, t;
        req = 2'b01;
        wait_gnt(g);
        send_byte(0, 8'hC3);
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (dev_cs_n !== 2'b11 || gnt !== 2'b00) begin
            n_err++;
            $display("FAIL reset_async: cs=%b gnt=%b, need 11 00", dev_cs_n, gnt);
        end
        req = 2'b00;
        tick(); tick();
        reset = 1'b1;
        t = 0;
        while (spi_busy !== 1'b0 && t < 20) begin
            n_cmp++;
            if (spi_start !== 1'b0) begin
                n_err++;
                $display("FAIL reset_spi_start: got %b, need 0", spi_start);
            end
            tick(); t++;
        end
        tick(); tick();
        n_cmp++;
        if (spi_start !== 1'b0 || busy !== 2'b00 || dev_cs_n !== 2'b11) begin
            n_err++;
            $display("FAIL reset_recover: spi_start=%b busy=%b cs=%b, need 0 00 11", spi_start, busy, dev_cs_n);
        end
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int g, ch;
        logic bad;
        req = 2'b10;
        wait_gnt(g);
        wait_cs_high(ch);
        n_cmp++;
        if (ch - (g + 2) != 19) begin
            n_err++;
            $display("FAIL timeout_revoke: CS high %0d cycles after ACTIVE, need 19", ch - (g + 2));
        end
        bad = 1'b0;
        repeat (10) begin
            if (busy[1] !== 1'b1 || gnt !== 2'b00) bad = 1'b1;
            tick();
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL timeout_busy_hold: busy1=%b gnt=%b seen, need 1 00", busy[1], gnt);
        end
        req = 2'b00;
        tick(); tick();
        n_cmp++;
        if (busy[1] !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_busy_clear: got %b, need 0", busy[1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_nongranted();
        test_early_release();
        test_reset_mid();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
